door_sprite_engine: RTL and testbench

DOOR_SPRITE_ENGINE -- requirements
Module: door_sprite_engine

---
 rtl/door_sprite_engine.sv | 199 +++++++++++++++++++
 tb/tb_door_sprite_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/door_sprite_engine.sv
// Door sprite engine: per-door open/close animation FSMs plus a one-stage
// registered pixel lookup that maps VGA counters to sprite-sheet ROM addresses.
//
// state   | meaning
// LOCKED  | door shut, frame index 0, waits for unlock
// OPENING | frame index climbs one step every TICKS_PER_FRAME frame ticks
// OPEN    | door fully open, frame index FRAMES-1, waits for lock
// CLOSING | frame index falls one step every TICKS_PER_FRAME frame ticks
module door_sprite_engine #(
  parameter int                      NUM_DOORS       = 4,
  parameter int                      SPR_W           = 20,
  parameter int                      SPR_H           = 20,
  parameter int                      FRAMES          = 4,
  parameter int                      TICKS_PER_FRAME = 6,
  parameter logic [NUM_DOORS*17-1:0] DOOR_POS        = {NUM_DOORS{9'd260, 8'd120}},
  parameter int                      SHEET_X0        = 120,
  parameter int                      SHEET_Y0        = 40,
  parameter logic [15:0]             ACTIVE_MASK     = 16'h0054
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           state,
  input  logic [9:0]           h_cnt,
  input  logic [9:0]           v_cnt,
  input  logic                 valid,
  input  logic                 frame_tick,
  input  logic [NUM_DOORS-1:0] isLocked,
  output logic [16:0]          pixel_addr,
  output logic                 isObject,
  output logic [2:0]           door_id,
  output logic [NUM_DOORS-1:0] door_open
);

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } door_st_e;

  localparam logic [2:0] FI_LAST = 3'(FRAMES - 1);
  localparam logic [5:0] PS_LAST = 6'(TICKS_PER_FRAME - 1);

  door_st_e   st_q [NUM_DOORS];
  door_st_e   st_d [NUM_DOORS];
  logic [2:0] fi_q [NUM_DOORS];
  logic [2:0] fi_d [NUM_DOORS];
  logic [5:0] ps_q [NUM_DOORS];
  logic [5:0] ps_d [NUM_DOORS];

  logic [16:0] pixel_addr_q, pixel_addr_d;
  logic        is_object_q, is_object_d;
  logic [2:0]  door_id_q, door_id_d;

  logic [8:0] x;
  logic [7:0] y;
  logic       unused_cnt_bits;

  assign x = h_cnt[9:1];
  assign y = v_cnt[8:1];
  // v_cnt never exceeds 479 and pixel pairs share an address.
  assign unused_cnt_bits = ^{h_cnt[0], v_cnt[0], v_cnt[9]};

  // Animation state registers for every door.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DOORS; k++) begin
        st_q[k] <= LOCKED;
        fi_q[k] <= 3'd0;
        ps_q[k] <= 6'd0;
      end
    end else begin
      for (int k = 0; k < NUM_DOORS; k++) begin
        st_q[k] <= st_d[k];
        fi_q[k] <= fi_d[k];
        ps_q[k] <= ps_d[k];
      end
    end
  end

  // Per-door next state; everything advances only on a frame tick.
  // A lock change mid-animation reverses direction keeping fi; the prescaler
  // restarts because that is a state entry.
  always_comb begin
    for (int k = 0; k < NUM_DOORS; k++) begin
      st_d[k] = st_q[k];
      fi_d[k] = fi_q[k];
      ps_d[k] = ps_q[k];
      if (frame_tick) begin
        case (st_q[k])
          LOCKED: begin
            fi_d[k] = 3'd0;
            if (!isLocked[k]) begin
              st_d[k] = OPENING;
              ps_d[k] = 6'd0;
            end
          end
          OPENING: begin
            if (isLocked[k]) begin
              ps_d[k] = 6'd0;
              st_d[k] = (fi_q[k] == 3'd0) ? LOCKED : CLOSING;
            end else if (ps_q[k] == PS_LAST) begin
              ps_d[k] = 6'd0;
              fi_d[k] = fi_q[k] + 3'd1;
              if (fi_q[k] + 3'd1 == FI_LAST) st_d[k] = OPEN;
            end else begin
              ps_d[k] = ps_q[k] + 6'd1;
            end
          end
          OPEN: begin
            fi_d[k] = FI_LAST;
            if (isLocked[k]) begin
              st_d[k] = CLOSING;
              ps_d[k] = 6'd0;
            end
          end
          CLOSING: begin
            if (!isLocked[k]) begin
              ps_d[k] = 6'd0;
              st_d[k] = (fi_q[k] == FI_LAST) ? OPEN : OPENING;
            end else if (ps_q[k] == PS_LAST) begin
              ps_d[k] = 6'd0;
              fi_d[k] = fi_q[k] - 3'd1;
              if (fi_q[k] == 3'd1) st_d[k] = LOCKED;
            end else begin
              ps_d[k] = ps_q[k] + 6'd1;
            end
          end
          default: begin
            st_d[k] = LOCKED;
            fi_d[k] = 3'd0;
            ps_d[k] = 6'd0;
          end
        endcase
      end
    end
  end

  // Hit test and ROM address; scanning from the top index down lets the
  // lowest-indexed overlapping door win.
  always_comb begin
    logic        hit;
    logic [2:0]  id;
    logic [8:0]  lx;
    logic [7:0]  ly;
    logic [2:0]  fi;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [16:0] addr;
    hit  = 1'b0;
    id   = 3'd0;
    lx   = 9'd0;
    ly   = 8'd0;
    fi   = 3'd0;
    x0   = 9'd0;
    y0   = 8'd0;
    addr = 17'd0;
    for (int k = NUM_DOORS - 1; k >= 0; k--) begin
      x0 = DOOR_POS[k*17+8 +: 9];
      y0 = DOOR_POS[k*17 +: 8];
      if ({1'b0, x} >= {1'b0, x0} && {1'b0, x} < {1'b0, x0} + 10'(SPR_W) &&
          {1'b0, y} >= {1'b0, y0} && {1'b0, y} < {1'b0, y0} + 9'(SPR_H)) begin
        hit = 1'b1;
        id  = 3'(k);
        lx  = x - x0;
        ly  = y - y0;
        fi  = fi_q[k];
      end
    end
    addr = (17'(SHEET_Y0) + 17'(ly)) * 17'd320 + 17'(SHEET_X0)
         + 17'(fi) * 17'(SPR_W) + 17'(lx);
    is_object_d  = valid && ACTIVE_MASK[state] && hit;
    door_id_d    = is_object_d ? id : 3'd0;
    pixel_addr_d = is_object_d ? addr : 17'd0;
  end

  // Output stage: one clock after the counter sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr_q <= 17'd0;
      is_object_q  <= 1'b0;
      door_id_q    <= 3'd0;
    end else begin
      pixel_addr_q <= pixel_addr_d;
      is_object_q  <= is_object_d;
      door_id_q    <= door_id_d;
    end
  end

  // Door status follows the state registers directly.
  always_comb begin
    for (int k = 0; k < NUM_DOORS; k++) door_open[k] = (st_q[k] == OPEN);
  end

  assign pixel_addr = pixel_addr_q;
  assign isObject   = is_object_q;
  assign door_id    = door_id_q;

endmodule

// File: tb/tb_door_sprite_engine.sv
// Directed bench for door_sprite_engine with default parameters.
module tb_door_sprite_engine;

  logic        clk;
  logic        rst_n;
  logic [3:0]  state;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        frame_tick;
  logic [3:0]  isLocked;
  logic [16:0] pixel_addr;
  logic        isObject;
  logic [2:0]  door_id;
  logic [3:0]  door_open;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic        obj;
    logic [2:0]  id;
    logic [16:0] addr;
  } exp_t;
  exp_t sbq[$];

  door_sprite_engine dut (
    .clk(clk), .rst_n(rst_n), .state(state), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid(valid), .frame_tick(frame_tick), .isLocked(isLocked),
    .pixel_addr(pixel_addr), .isObject(isObject), .door_id(door_id),
    .door_open(door_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: all four doors share the default box, door 0 always wins.
  task automatic model(input int h, input int v, input int vld, input int st,
                       input int fi0, output exp_t e);
    int x, y;
    bit hit, act;
    x   = h / 2;
    y   = v / 2;
    hit = (x >= 260) && (x < 280) && (y >= 120) && (y < 140);
    act = ((32'h0054 >> st) & 1) != 0;
    e.obj  = (vld != 0) && act && hit;
    e.id   = 3'd0;
    e.addr = e.obj ? 17'((40 + y - 120) * 320 + 120 + fi0 * 20 + (x - 260)) : 17'd0;
  endtask

  task automatic pix(input string tag, input int h, input int v, input int vld,
                     input int st, input int fi0);
    exp_t e, got;
    @(negedge clk);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    valid = 1'(vld);
    state = 4'(st);
    model(h, v, vld, st, fi0, e);
    e.tag = tag;
    sbq.push_back(e);
    @(negedge clk);
    valid = 1'b0;
    if (sbq.size() == 0) begin
      chk({tag, "_sbq"}, 32'd0, 32'd1);
    end else begin
      got = sbq.pop_front();
      chk({got.tag, "_obj"}, 32'(isObject), 32'(got.obj));
      chk({got.tag, "_id"}, 32'(door_id), 32'(got.id));
      chk({got.tag, "_addr"}, 32'(pixel_addr), 32'(got.addr));
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    int bh[7];
    int bv[7];
    int bvld[7];
    bh   = '{520, 559, 560, 519, 520, 520, 530};
    bv   = '{240, 240, 240, 240, 278, 280, 254};
    bvld = '{1,   1,   1,   1,   1,   1,   0};

    if ((40 + 19) * 320 + 120 + 3 * 20 + 19 >= 76800) begin
      $display("FAIL addr_range observed=overflow expected=below_76800");
      $fatal(1, "illegal configuration");
    end

    rst_n = 1'b0; state = 4'd2; h_cnt = 10'd0; v_cnt = 10'd0; valid = 1'b0;
    frame_tick = 1'b0; isLocked = 4'hF;
    #12;
    chk("rst_addr", 32'(pixel_addr), 32'd0);
    chk("rst_obj", 32'(isObject), 32'd0);
    chk("rst_id", 32'(door_id), 32'd0);
    chk("rst_open", 32'(door_open), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    pix("locked_origin", 520, 240, 1, 2, 0);
    for (int i = 0; i < 7; i++) pix($sformatf("bound%0d", i), bh[i], bv[i], bvld[i], 2, 0);
    pix("interior", 530, 254, 1, 2, 0);
    pix("title_blank", 520, 240, 1, 0, 0);
    pix("stage2", 520, 240, 1, 4, 0);
    pix("stage3", 520, 240, 1, 6, 0);
    pix("state3_blank", 520, 240, 1, 3, 0);

    isLocked = 4'b1110;
    tick(1);
    chk("opening_entry_open", 32'(door_open), 32'd0);
    tick(5);
    pix("open_t5", 520, 240, 1, 2, 0);
    tick(1);
    pix("open_t6", 520, 240, 1, 2, 1);
    pix("open_t6_title", 520, 240, 1, 0, 1);
    tick(6);
    pix("open_t12", 520, 240, 1, 2, 2);
    tick(5);
    chk("open_t17_status", 32'(door_open), 32'd0);
    tick(1);
    chk("open_t18_status", 32'(door_open), 32'd1);
    pix("open_t18", 520, 240, 1, 2, 3);

    isLocked = 4'hF;
    tick(1);
    chk("closing_entry_status", 32'(door_open), 32'd0);
    pix("closing_entry", 520, 240, 1, 2, 3);
    tick(18);
    pix("closed_full", 520, 240, 1, 2, 0);

    isLocked = 4'b1110;
    tick(13);
    pix("reopen_fi2", 520, 240, 1, 2, 2);
    isLocked = 4'hF;
    tick(1);
    pix("reverse_fi2", 520, 240, 1, 2, 2);
    tick(5);
    pix("reverse_t5", 520, 240, 1, 0, 2);
    pix("reverse_t5_vis", 520, 240, 1, 2, 2);
    tick(1);
    pix("reverse_t6", 520, 240, 1, 2, 1);
    tick(6);
    pix("reverse_t12", 520, 240, 1, 2, 0);
    chk("reverse_locked_status", 32'(door_open), 32'd0);

    isLocked = 4'b1110;
    tick(7);
    pix("pre_reset_fi1", 520, 240, 1, 2, 1);
    @(negedge clk);
    h_cnt = 10'd520; v_cnt = 10'd240; valid = 1'b1; state = 4'd2;
    @(negedge clk);
    chk("pre_reset_obj", 32'(isObject), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_obj", 32'(isObject), 32'd0);
    chk("async_rst_addr", 32'(pixel_addr), 32'd0);
    chk("async_rst_id", 32'(door_id), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pix("post_reset_fi0", 520, 240, 1, 2, 0);
    tick(1);
    tick(5);
    pix("post_reset_t5", 520, 240, 1, 2, 0);
    tick(1);
    pix("post_reset_t6", 520, 240, 1, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
